// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

  localparam int BYTE_W    = 8;
  localparam int HDR_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    DATA,
    WRITE,
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/imem_byte_assembler.sv
// Byte-lane counter plus little-endian insert register; the first byte lands in bits [7:0].
module imem_byte_assembler
  import imem_loader_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              last,
  output logic [OUT_W-1:0]  word_nxt
);

  localparam int LANES = OUT_W / BYTE_W;
  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic [CNT_W-1:0] cnt;
  logic [OUT_W-1:0] word_q;

  assign last = (int'(cnt) == LANES - 1);

  // word_nxt already contains the byte being accepted, so the consumer can act on it in the same cycle
  always_comb begin
    word_nxt = word_q;
    if (byte_en) begin
      word_nxt[BYTE_W*int'(cnt) +: BYTE_W] = byte_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (byte_en) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    word_q <= word_nxt;
  end

endmodule

// File: rtl/imem_program_loader.sv
// Streams a length-prefixed instruction image into instruction memory through the
// debug write port, keeping the fetch stage held until the image is complete.
module imem_program_loader
  import imem_loader_pkg::*;
#(
  parameter int              XLEN               = 64,
  parameter int              INSTRUCTION_LENGTH = XLEN / 2,
  parameter logic [XLEN-1:0] BASE_ADDR          = '0,
  parameter int              MAX_WORDS          = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic [BYTE_W-1:0]             in_data,
  output logic                          in_ready,
  output logic                          dbg_wr_en,
  output logic [XLEN-1:0]               dbg_addr,
  output logic [INSTRUCTION_LENGTH-1:0] dbg_instr,
  output logic                          cpu_hold,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [31:0]                   words_loaded
);

  localparam int HDR_W = HDR_BYTES * BYTE_W;

  loader_state_t state, state_nxt;

  logic                          clr;
  logic                          hdr_en, hdr_last, dat_en, dat_last;
  logic [HDR_W-1:0]              hdr_word_nxt;
  logic [INSTRUCTION_LENGTH-1:0] dat_word_nxt;
  logic [31:0]                   count_q;
  logic [31:0]                   word_idx;
  logic                          hdr_bad;
  logic                          last_word;

  assign hdr_en    = (state == HEADER) && in_valid;
  assign dat_en    = (state == DATA) && in_valid;
  assign hdr_bad   = (hdr_word_nxt == '0) || (hdr_word_nxt > 32'(MAX_WORDS));
  assign last_word = (word_idx + 32'd1 == count_q);

  imem_byte_assembler #(.OUT_W(HDR_W)) u_hdr_asm (
    .clk      (clk),
    .rst      (rst),
    .clear    (clr),
    .byte_en  (hdr_en),
    .byte_in  (in_data),
    .last     (hdr_last),
    .word_nxt (hdr_word_nxt)
  );

  imem_byte_assembler #(.OUT_W(INSTRUCTION_LENGTH)) u_dat_asm (
    .clk      (clk),
    .rst      (rst),
    .clear    (clr),
    .byte_en  (dat_en),
    .byte_in  (in_data),
    .last     (dat_last),
    .word_nxt (dat_word_nxt)
  );

  // All status outputs decode straight from the registered state
  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    in_ready  = 1'b0;
    dbg_wr_en = 1'b0;
    cpu_hold  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = HEADER;
          clr       = 1'b1;
        end
      end
      HEADER: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        busy     = 1'b1;
        if (in_valid && hdr_last) begin
          state_nxt = hdr_bad ? ERROR : DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        busy     = 1'b1;
        if (in_valid && dat_last) begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        dbg_wr_en = 1'b1;
        cpu_hold  = 1'b1;
        busy      = 1'b1;
        state_nxt = last_word ? DONE : DATA;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      ERROR: begin
        error    = 1'b1;
        cpu_hold = 1'b1;
        if (start) begin
          state_nxt = HEADER;
          clr       = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      word_idx     <= '0;
      dbg_addr     <= '0;
      dbg_instr    <= '0;
      words_loaded <= '0;
    end else begin
      state <= state_nxt;
      if (clr) begin
        word_idx <= '0;
      end else if (state == WRITE) begin
        word_idx <= word_idx + 32'd1;
      end
      // Address and data are captured as the last byte lands so they are stable for the WRITE cycle
      if (dat_en && dat_last) begin
        dbg_addr  <= BASE_ADDR + XLEN'(word_idx);
        dbg_instr <= dat_word_nxt;
      end
      if (state == WRITE && last_word) begin
        words_loaded <= count_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (hdr_en && hdr_last) begin
      count_q <= hdr_word_nxt;
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Bench for imem_program_loader: table vectors, hand sequences and random images vs. a reference model.
module tb_imem_program_loader;

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [7:0]  in_data;

  logic        in_ready_a, dbg_wr_en_a, cpu_hold_a, busy_a, done_a, error_a;
  logic [63:0] dbg_addr_a;
  logic [31:0] dbg_instr_a, words_loaded_a;
  logic        in_ready_b, dbg_wr_en_b, cpu_hold_b, busy_b, done_b, error_b;
  logic [63:0] dbg_addr_b;
  logic [31:0] dbg_instr_b, words_loaded_b;

  always #5 clk = ~clk;

  imem_program_loader dut_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_a), .dbg_wr_en(dbg_wr_en_a), .dbg_addr(dbg_addr_a), .dbg_instr(dbg_instr_a),
    .cpu_hold(cpu_hold_a), .busy(busy_a), .done(done_a), .error(error_a), .words_loaded(words_loaded_a)
  );

  imem_program_loader #(.BASE_ADDR(64'h100)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_b), .dbg_wr_en(dbg_wr_en_b), .dbg_addr(dbg_addr_b), .dbg_instr(dbg_instr_b),
    .cpu_hold(cpu_hold_b), .busy(busy_b), .done(done_b), .error(error_b), .words_loaded(words_loaded_b)
  );

  int n_pass = 0, n_total = 0;
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Write/done recorders, one per instance
  logic [63:0] wa_addr [1024];
  logic [31:0] wa_data [1024];
  int wa_n = 0, wa_viol = 0, da_n = 0, last_wr_cyc_a = 0, done_cyc_a = 0;
  bit prev_wr_a = 1'b0;
  always @(negedge clk) begin
    if (dbg_wr_en_a) begin
      wa_addr[10'(wa_n)] <= dbg_addr_a;
      wa_data[10'(wa_n)] <= dbg_instr_a;
      wa_n <= wa_n + 1;
      last_wr_cyc_a <= cyc_n;
      if (in_ready_a || prev_wr_a) wa_viol <= wa_viol + 1;
    end
    if (done_a) begin
      da_n <= da_n + 1;
      done_cyc_a <= cyc_n;
    end
    prev_wr_a <= dbg_wr_en_a;
  end

  logic [63:0] wb_addr [1024];
  logic [31:0] wb_data [1024];
  int wb_n = 0, wb_viol = 0, db_n = 0;
  bit prev_wr_b = 1'b0;
  always @(negedge clk) begin
    if (dbg_wr_en_b) begin
      wb_addr[10'(wb_n)] <= dbg_addr_b;
      wb_data[10'(wb_n)] <= dbg_instr_b;
      wb_n <= wb_n + 1;
      if (in_ready_b || prev_wr_b) wb_viol <= wb_viol + 1;
    end
    if (done_b) db_n <= db_n + 1;
    prev_wr_b <= dbg_wr_en_b;
  end

  int hold_bad, last_ok, last_hs_cyc;

  typedef struct {
    logic [127:0] bytes;
    int           nb;
    int           gap;
    bit           exp_err;
    int           exp_n;
    logic [31:0]  exp_w0;
    logic [31:0]  exp_w1;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic bytes_to_q(input logic [127:0] v, input int nb, output logic [7:0] q[$]);
    q = {};
    for (int i = 0; i < nb; i++) q.push_back(v[8*i +: 8]);
  endtask

  // Reference: header is a little-endian count, each instruction is 4 little-endian bytes
  task automatic model(input logic [7:0] img[$], output bit err, output int n, output logic [31:0] w[$]);
    logic [31:0] hdr;
    hdr = {img[3], img[2], img[1], img[0]};
    err = (hdr == 32'd0) || (hdr > 32'd1024);
    n = err ? 0 : int'(hdr);
    w = {};
    for (int k = 0; k < n; k++)
      w.push_back({img[4+4*k+3], img[4+4*k+2], img[4+4*k+1], img[4+4*k]});
  endtask

  task automatic gen_image(input int forced_n, output logic [7:0] img[$]);
    int kind, n;
    logic [31:0] hdr;
    kind = $urandom_range(0, 9);
    n = (forced_n > 0) ? forced_n : $urandom_range(1, 6);
    if (forced_n > 0) hdr = 32'(forced_n);
    else if (kind == 0) hdr = 32'd0;
    else if (kind == 1) hdr = 32'(1025 + $urandom_range(0, 100000));
    else hdr = 32'(n);
    img = {};
    for (int b = 0; b < 4; b++) img.push_back(hdr[8*b +: 8]);
    if (forced_n > 0 || kind > 1)
      for (int j = 0; j < 4*n; j++) img.push_back(8'($urandom));
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic stream(input logic [7:0] img[$], input int gap, input int first, input int stop_at,
                        input bit wait_end, output int consumed);
    int i, cyc;
    i = first;
    cyc = 0;
    while (cyc < 20000) begin
      if (done_a || error_a) break;
      if (!wait_end && i >= stop_at) break;
      if (!cpu_hold_a) hold_bad++;
      in_valid = 1'b0;
      if (i < stop_at) begin
        in_valid = ($urandom_range(0, 99) >= 32'(gap));
        in_data = img[i];
        if (in_valid && in_ready_a) begin
          i++;
          last_hs_cyc = cyc_n;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    if (cyc >= 20000) begin
      n_total++;
      $display("FAIL timeout: stream stuck at byte %0d of %0d", i, stop_at);
    end
    consumed = i;
  endtask

  task automatic verify_writes(input string tag, input logic [31:0] w[$], input int wa0, input int wb0);
    check({tag, "/nwr_a"}, 64'(wa_n - wa0), 64'(w.size()));
    check({tag, "/nwr_b"}, 64'(wb_n - wb0), 64'(w.size()));
    for (int k = 0; k < w.size() && k < wa_n - wa0 && k < wb_n - wb0; k++) begin
      check($sformatf("%s/addr_a%0d", tag, k), wa_addr[10'(wa0+k)], 64'(k));
      check($sformatf("%s/data_a%0d", tag, k), 64'(wa_data[10'(wa0+k)]), 64'(w[k]));
      check($sformatf("%s/addr_b%0d", tag, k), wb_addr[10'(wb0+k)], 64'h100 + 64'(k));
      check($sformatf("%s/data_b%0d", tag, k), 64'(wb_data[10'(wb0+k)]), 64'(w[k]));
    end
  endtask

  task automatic do_load(input string tag, input logic [7:0] img[$], input int gap,
                         input bit exp_err, input int exp_n, input logic [31:0] w[$]);
    int wa0, wb0, da0, db0, va0, vb0, cons;
    wa0 = wa_n; wb0 = wb_n; da0 = da_n; db0 = db_n; va0 = wa_viol; vb0 = wb_viol;
    hold_bad = 0;
    pulse_start();
    check({tag, "/err_clr"}, 64'(error_a), 64'(0));
    stream(img, gap, 0, img.size(), 1'b1, cons);
    if (exp_err) begin
      check({tag, "/consumed"}, 64'(cons), 64'(4));
      check({tag, "/error"}, 64'(error_a), 64'(1));
      repeat (3) begin @(posedge clk); #1; end
      check({tag, "/error_sticky"}, 64'(error_a), 64'(1));
      check({tag, "/hold_err"}, 64'(cpu_hold_a), 64'(1));
      check({tag, "/busy_err"}, 64'(busy_a), 64'(0));
      check({tag, "/error_b"}, 64'(error_b), 64'(1));
      check({tag, "/hold_err_b"}, 64'(cpu_hold_b), 64'(1));
    end else begin
      check({tag, "/consumed"}, 64'(cons), 64'(img.size()));
      check({tag, "/done"}, 64'(done_a), 64'(1));
      check({tag, "/hold_at_done"}, 64'(cpu_hold_a), 64'(0));
      check({tag, "/busy_at_done"}, 64'(busy_a), 64'(0));
      check({tag, "/words_loaded"}, 64'(words_loaded_a), 64'(exp_n));
      check({tag, "/done_b"}, 64'(done_b), 64'(1));
      check({tag, "/words_loaded_b"}, 64'(words_loaded_b), 64'(exp_n));
      last_ok = exp_n;
      @(posedge clk); #1;
      check({tag, "/done_pulse"}, 64'(done_a), 64'(0));
      check({tag, "/wr_latency"}, 64'(last_wr_cyc_a), 64'(last_hs_cyc + 1));
      check({tag, "/done_latency"}, 64'(done_cyc_a), 64'(last_hs_cyc + 2));
    end
    check({tag, "/words_kept"}, 64'(words_loaded_a), 64'(last_ok));
    check({tag, "/hold_during_load"}, 64'(hold_bad), 64'(0));
    check({tag, "/wr_viol_a"}, 64'(wa_viol - va0), 64'(0));
    check({tag, "/wr_viol_b"}, 64'(wb_viol - vb0), 64'(0));
    check({tag, "/ndone_a"}, 64'(da_n - da0), exp_err ? 64'(0) : 64'(1));
    check({tag, "/ndone_b"}, 64'(db_n - db0), exp_err ? 64'(0) : 64'(1));
    verify_writes(tag, w, wa0, wb0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  img[$];
    logic [7:0]  basic[$];
    logic [31:0] w[$];
    bit err;
    int n, wa0, wb0, da0, db0, cons;

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    last_ok = 0; hold_bad = 0; last_hs_cyc = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("rst/in_ready", 64'(in_ready_a), 64'(0));
    check("rst/dbg_wr_en", 64'(dbg_wr_en_a), 64'(0));
    check("rst/dbg_addr", dbg_addr_a, 64'(0));
    check("rst/dbg_addr_b", dbg_addr_b, 64'(0));
    check("rst/dbg_instr", 64'(dbg_instr_a), 64'(0));
    check("rst/cpu_hold", 64'(cpu_hold_a), 64'(0));
    check("rst/busy", 64'(busy_a), 64'(0));
    check("rst/done", 64'(done_a), 64'(0));
    check("rst/error", 64'(error_a), 64'(0));
    check("rst/words_loaded", 64'(words_loaded_a), 64'(0));

    vecs[0] = '{96'h002005930010051300000002, 12, 0,  1'b0, 2, 32'h00100513, 32'h00200593};
    vecs[1] = '{96'h002005930010051300000002, 12, 50, 1'b0, 2, 32'h00100513, 32'h00200593};
    vecs[2] = '{128'h0,                        4,  0,  1'b1, 0, 32'h0,        32'h0};
    vecs[3] = '{96'h002005930010051300000002, 12, 25, 1'b0, 2, 32'h00100513, 32'h00200593};
    vecs[4] = '{128'h00000401,                 4,  0,  1'b1, 0, 32'h0,        32'h0};
    vecs[5] = '{64'hDEADBEEF00000001,         8,  30, 1'b0, 1, 32'hDEADBEEF, 32'h0};

    for (int v = 0; v < 6; v++) begin
      bytes_to_q(vecs[v].bytes, vecs[v].nb, img);
      w = {};
      if (!vecs[v].exp_err) w.push_back(vecs[v].exp_w0);
      if (!vecs[v].exp_err && vecs[v].exp_n > 1) w.push_back(vecs[v].exp_w1);
      do_load($sformatf("vec%0d", v), img, vecs[v].gap, vecs[v].exp_err, vecs[v].exp_n, w);
    end

    // Reset after the header plus 6 data bytes
    bytes_to_q(96'h002005930010051300000002, 12, basic);
    wa0 = wa_n; wb0 = wb_n;
    pulse_start();
    stream(basic, 0, 0, 10, 1'b0, cons);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_ok = 0;
    check("midrst/cpu_hold", 64'(cpu_hold_a), 64'(0));
    check("midrst/in_ready", 64'(in_ready_a), 64'(0));
    check("midrst/busy", 64'(busy_a), 64'(0));
    check("midrst/dbg_wr_en", 64'(dbg_wr_en_a), 64'(0));
    check("midrst/dbg_addr", dbg_addr_a, 64'(0));
    check("midrst/words_loaded", 64'(words_loaded_a), 64'(0));
    in_valid = 1'b1; in_data = 8'hA5;
    repeat (4) begin @(posedge clk); #1; end
    check("midrst/in_ready_idle", 64'(in_ready_a), 64'(0));
    in_valid = 1'b0;
    w = {32'h00100513};
    verify_writes("midrst", w, wa0, wb0);
    w = {32'h00100513, 32'h00200593};
    do_load("after_rst", basic, 10, 1'b0, 2, w);

    // start raised in the middle of DATA must be ignored
    wa0 = wa_n; wb0 = wb_n; da0 = da_n; db0 = db_n;
    pulse_start();
    stream(basic, 0, 0, 10, 1'b0, cons);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("midstart/busy", 64'(busy_a), 64'(1));
    stream(basic, 30, 10, 12, 1'b1, cons);
    check("midstart/done", 64'(done_a), 64'(1));
    check("midstart/done_b", 64'(done_b), 64'(1));
    @(posedge clk); #1;
    check("midstart/ndone_a", 64'(da_n - da0), 64'(1));
    check("midstart/ndone_b", 64'(db_n - db0), 64'(1));
    verify_writes("midstart", w, wa0, wb0);
    last_ok = 2;

    for (int r = 0; r < 25; r++) begin
      gen_image(0, img);
      model(img, err, n, w);
      do_load($sformatf("rnd%0d", r), img, $urandom_range(0, 60), err, n, w);
    end

    gen_image(1024, img);
    model(img, err, n, w);
    do_load("max_words", img, 0, err, n, w);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
